apb_requester: RTL and testbench

- Synthesisable APB4 requester; replaces the behavioural bridge as the real bus initiator.
- Accepts read and write commands on a valid/ready command port.
- Decodes the target into one of NUM_SLAVES one-hot PSEL lines and runs SETUP/ACCESS phases with wait states.
- Returns data and error status on a valid/ready response port.
- Local error checks (unaligned address, decode miss) complete without bus activity.

---
 rtl/apb_requester_if.sv | 27 ++
 rtl/apb_requester.sv | 172 +++++++++++++++++
 tb/tb_apb_requester.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_requester_if.sv
// APB4 bus bundle between the requester (master) and its slaves.
interface apb_requester_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLAVES = 4
);
    logic [NUM_SLAVES-1:0]            psel;
    logic                             penable;
    logic                             pwrite;
    logic [ADDR_WIDTH-1:0]            paddr;
    logic [DATA_WIDTH-1:0]            pwdata;
    logic [DATA_WIDTH/8-1:0]          pstrb;
    logic [2:0]                       pprot;
    logic [NUM_SLAVES-1:0]            pready;
    logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata;
    logic [NUM_SLAVES-1:0]            pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_requester.sv
// APB4 requester: valid/ready command in, SETUP/ACCESS on the bus, valid/ready response out.
// Optional ACCESS timeout is enabled by defining APB_TIMEOUT_EN.
module apb_requester #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SLAVES     = 4,
    parameter int SLAVE_SHIFT    = 12,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    pclk,
    input  logic                    preset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
    input  logic [2:0]              cmd_prot,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic [1:0]              rsp_code,
    apb_requester_if.master         apb
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_W - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam logic [1:0] CODE_OK     = 2'd0;
    localparam logic [1:0] CODE_SLVERR = 2'd1;
    localparam logic [1:0] CODE_DECERR = 2'd2;

    if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_dw
        $error("apb_requester: DATA_WIDTH must be 8, 16, 32 or 64");
    end
    if (NUM_SLAVES < 1 || NUM_SLAVES > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("apb_requester: NUM_SLAVES must be 1..16 and TIMEOUT_CYCLES >= 1");
    end

    logic [1:0]              state;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [STRB_W-1:0]       strb_q;
    logic [2:0]              prot_q;
    logic                    write_q;
    logic [IDX_W-1:0]        idx_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [1:0]              code_q;

    logic [ADDR_WIDTH-1:0]   slave_full;
    logic                    misaligned;
    logic                    decode_miss;
    logic [NUM_SLAVES-1:0]   sel_onehot;
    logic                    sel_ready;
    logic                    sel_err;
    logic [DATA_WIDTH-1:0]   sel_rdata;

`ifdef APB_TIMEOUT_EN
    localparam logic [1:0] CODE_TIMEOUT = 2'd3;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] wait_cnt;
`endif

    always_comb begin
        slave_full  = cmd_addr >> SLAVE_SHIFT;
        misaligned  = (cmd_addr & ALIGN_MASK) != '0;
        decode_miss = slave_full >= ADDR_WIDTH'(NUM_SLAVES);
    end

    // Only the latched target's pready/pslverr/prdata are ever looked at.
    always_comb begin
        sel_onehot = '0;
        sel_ready  = 1'b0;
        sel_err    = 1'b0;
        sel_rdata  = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_onehot[i] = 1'b1;
                sel_ready     = apb.pready[i];
                sel_err       = apb.pslverr[i];
                sel_rdata     = apb.prdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign cmd_ready   = (state == S_IDLE);
    assign rsp_valid   = (state == S_RESP);
    assign rsp_rdata   = rdata_q;
    assign rsp_code    = code_q;
    assign rsp_err     = (code_q != CODE_OK);

    assign apb.psel    = (state == S_SETUP || state == S_ACCESS) ? sel_onehot : '0;
    assign apb.penable = (state == S_ACCESS);
    assign apb.pwrite  = write_q;
    assign apb.paddr   = addr_q;
    assign apb.pwdata  = wdata_q;
    assign apb.pstrb   = write_q ? strb_q : '0;
    assign apb.pprot   = prot_q;

    always_ff @(posedge pclk) begin
        if (preset) begin
            state   <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            prot_q  <= '0;
            write_q <= 1'b0;
            idx_q   <= '0;
            rdata_q <= '0;
            code_q  <= CODE_OK;
`ifdef APB_TIMEOUT_EN
            wait_cnt <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        addr_q  <= cmd_addr;
                        wdata_q <= cmd_wdata;
                        strb_q  <= cmd_strb;
                        prot_q  <= cmd_prot;
                        write_q <= cmd_write;
                        idx_q   <= IDX_W'(slave_full);
                        // Local decode errors never touch the bus.
                        if (misaligned || decode_miss) begin
                            code_q  <= CODE_DECERR;
                            rdata_q <= '0;
                            state   <= S_RESP;
                        end else begin
                            state   <= S_SETUP;
                        end
                    end
                end
                S_SETUP: begin
                    state <= S_ACCESS;
`ifdef APB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                S_ACCESS: begin
                    if (sel_ready) begin
                        code_q  <= sel_err ? CODE_SLVERR : CODE_OK;
                        rdata_q <= (write_q || sel_err) ? '0 : sel_rdata;
                        state   <= S_RESP;
                    end
`ifdef APB_TIMEOUT_EN
                    else if (wait_cnt == CNT_LAST) begin
                        code_q  <= CODE_TIMEOUT;
                        rdata_q <= '0;
                        state   <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
`endif
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_requester.sv
// Randomized scoreboard bench for apb_requester: a transaction-level model predicts each
// response, latency and bus phase count; a monitor compares as the DUT presents them.
module tb_apb_requester;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 4;
    localparam int TO = 16;

    logic        pclk = 1'b0;
    logic        preset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_strb = '0;
    logic [2:0]  cmd_prot = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [1:0]  rsp_code;

    apb_requester_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS)) bus ();

    apb_requester #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS),
        .SLAVE_SHIFT(12), .TIMEOUT_CYCLES(TO)
    ) dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_code(rsp_code),
        .apb(bus)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        int          idx;
        logic [1:0]  code;
        logic [31:0] rdata;
        int          latency;
        int          pen_cycles;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    int          cfg_idx = 0;
    int          cfg_wait = 0;
    logic        cfg_err = 1'b0;
    logic [31:0] cfg_data = '0;
    int          acc_n = 0;
    int          hold_left = 0;
    logic        random_bp = 1'b0;

    always @(posedge pclk) cyc++;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Transaction-level prediction from the decode, wait and error rules.
    function automatic exp_t model(input logic write, input logic [31:0] addr, input logic [31:0] wdata,
                                   input logic [3:0] strb, input logic [2:0] prot,
                                   input int wait_n, input logic err, input logic [31:0] data);
        exp_t e;
        e.write = write; e.addr = addr; e.wdata = wdata; e.strb = strb; e.prot = prot;
        e.idx = int'(addr >> 12);
        if ((addr % (DW / 8)) != 0 || e.idx >= NS) begin
            e.code = 2'd2; e.rdata = '0; e.latency = 1; e.pen_cycles = 0;
        end else begin
            e.code = err ? 2'd1 : 2'd0;
            e.rdata = (write || err) ? 32'd0 : data;
            e.latency = 3 + wait_n;
            e.pen_cycles = wait_n + 1;
`ifdef APB_TIMEOUT_EN
            if (wait_n >= TO) begin
                e.code = 2'd3; e.rdata = '0; e.latency = 2 + TO; e.pen_cycles = TO;
            end
`endif
        end
        return e;
    endfunction

    // Slave side: random noise on every lane, the configured target answers after cfg_wait cycles.
    always @(negedge pclk) begin
        if (bus.penable && bus.psel != '0) acc_n++;
        else acc_n = 0;
        for (int i = 0; i < NS; i++) begin
            bus.pready[i]  = 1'($urandom_range(0, 1));
            bus.pslverr[i] = 1'($urandom_range(0, 1));
            bus.prdata[i*DW +: DW] = $urandom;
        end
        bus.prdata[cfg_idx*DW +: DW] = cfg_data;
        bus.pslverr[cfg_idx] = cfg_err;
        if (bus.penable && bus.psel[cfg_idx]) bus.pready[cfg_idx] = (acc_n > cfg_wait);
    end

    always @(posedge pclk) begin
        #1;
        if (hold_left > 0 && rsp_valid) begin
            rsp_ready = 1'b0;
            hold_left--;
        end else if (random_bp) begin
            rsp_ready = ($urandom_range(0, 2) != 0);
        end else begin
            rsp_ready = 1'b1;
        end
    end

    exp_t cur;
    logic cur_ok = 1'b0;
    logic resp_seen = 1'b0;
    int   pending = 0;
    int   pen_cnt = 0;
    int   psel_cnt = 0;
    int   acc_cyc;

    // Monitor: bus phase checks against the head transaction, response checks on rsp_valid.
    always @(negedge pclk) begin
        if (preset) begin
            resp_seen = 1'b0; cur_ok = 1'b0; pending = 0; pen_cnt = 0; psel_cnt = 0;
            acc_q.delete();
        end else begin
            if (bus.psel != '0) begin
                psel_cnt++;
                if (bus.penable) pen_cnt++;
                if (exp_q.size() == 0) begin
                    check_output("psel_without_cmd", 64'(bus.psel), 64'd0);
                end else begin
                    check_output("psel", 64'(bus.psel), (exp_q[0].code == 2'd2) ? 64'd0 : (64'd1 << exp_q[0].idx));
                    check_output("paddr", 64'(bus.paddr), 64'(exp_q[0].addr));
                    check_output("pwrite", 64'(bus.pwrite), 64'(exp_q[0].write));
                    check_output("pwdata", 64'(bus.pwdata), 64'(exp_q[0].wdata));
                    check_output("pstrb", 64'(bus.pstrb), exp_q[0].write ? 64'(exp_q[0].strb) : 64'd0);
                    check_output("pprot", 64'(bus.pprot), 64'(exp_q[0].prot));
                    check_output("cmd_ready_on_bus", 64'(cmd_ready), 64'd0);
                end
            end else begin
                check_output("penable_without_psel", 64'(bus.penable), 64'd0);
            end

            if (rsp_valid) begin
                check_output("cmd_ready_in_resp", 64'(cmd_ready), 64'd0);
                if (!resp_seen) begin
                    resp_seen = 1'b1;
                    if (exp_q.size() == 0 || acc_q.size() == 0) begin
                        cur_ok = 1'b0;
                        check_output("unexpected_rsp", 64'(rsp_valid), 64'd0);
                    end else begin
                        cur = exp_q.pop_front();
                        acc_cyc = acc_q.pop_front();
                        cur_ok = 1'b1;
                        check_output("rsp_code", 64'(rsp_code), 64'(cur.code));
                        check_output("rsp_err", 64'(rsp_err), 64'(cur.code != 2'd0));
                        check_output("rsp_rdata", 64'(rsp_rdata), 64'(cur.rdata));
                        check_output("latency", 64'(cyc - acc_cyc), 64'(cur.latency));
                        check_output("penable_cycles", 64'(pen_cnt), 64'(cur.pen_cycles));
                        check_output("psel_cycles", 64'(psel_cnt), (cur.pen_cycles == 0) ? 64'd0 : 64'(cur.pen_cycles + 1));
                    end
                end else if (cur_ok) begin
                    check_output("rsp_hold_code", 64'(rsp_code), 64'(cur.code));
                    check_output("rsp_hold_rdata", 64'(rsp_rdata), 64'(cur.rdata));
                end
                if (rsp_ready) begin
                    resp_seen = 1'b0;
                    pending--;
                end
            end

            if (cmd_valid && cmd_ready) begin
                check_output("accept_while_pending", 64'(pending), 64'd0);
                pending++;
                acc_q.push_back(cyc);
                pen_cnt = 0;
                psel_cnt = 0;
            end
        end
    end

    task automatic apply_stimulus(input logic write, input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [3:0] strb, input logic [2:0] prot, input int wait_n,
                                  input logic err, input logic [31:0] data, input logic early);
        exp_t e;
        int   n;
        logic hs;
        e = model(write, addr, wdata, strb, prot, wait_n, err, data);
        @(posedge pclk); #1;
        if (!early) begin
            n = 0;
            while (!cmd_ready && n < 500) begin
                @(posedge pclk); #1;
                n++;
            end
            if (!cmd_ready) check_output("cmd_ready_wait", 64'(cmd_ready), 64'd1);
        end
        exp_q.push_back(e);
        cfg_idx = (e.idx < NS) ? e.idx : 0;
        cfg_wait = wait_n; cfg_err = err; cfg_data = data;
        cmd_valid = 1'b1; cmd_write = write; cmd_addr = addr;
        cmd_wdata = wdata; cmd_strb = strb; cmd_prot = prot;
        n = 0;
        forever begin
            @(negedge pclk) hs = cmd_ready;
            @(posedge pclk); #1;
            if (hs) break;
            n++;
            if (n > 500) begin
                check_output("cmd_accept_wait", 64'(hs), 64'd1);
                break;
            end
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp_valid();
        int n = 0;
        while (!rsp_valid && n < 100) begin
            @(posedge pclk); #1;
            n++;
        end
        if (!rsp_valid) check_output("rsp_valid_wait", 64'(rsp_valid), 64'd1);
    endtask

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int   n;
        int   slave;
        int   wait_n;
        logic [31:0] addr;

        repeat (3) @(negedge pclk);
        check_output("reset_cmd_ready", 64'(cmd_ready), 64'd1);
        check_output("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check_output("reset_psel", 64'(bus.psel), 64'd0);
        check_output("reset_penable", 64'(bus.penable), 64'd0);
        check_output("reset_paddr", 64'(bus.paddr), 64'd0);
        check_output("reset_rsp_code", 64'(rsp_code), 64'd0);
        preset = 1'b0;

        apply_stimulus(1'b0, 32'h0000_1004, 32'h0, 4'hF, 3'b000, 2, 1'b0, 32'hDEAD_BEEF, 1'b0);
        apply_stimulus(1'b1, 32'h0000_0008, 32'h1234_5678, 4'b0101, 3'b010, 0, 1'b0, 32'h5555_AAAA, 1'b0);
        apply_stimulus(1'b0, 32'h0000_0003, 32'h0, 4'h0, 3'b000, 0, 1'b0, 32'h1111_2222, 1'b0);
        apply_stimulus(1'b0, 32'h0000_4000, 32'h0, 4'h0, 3'b000, 0, 1'b0, 32'h3333_4444, 1'b0);
        apply_stimulus(1'b0, 32'h0000_2010, 32'h0, 4'h0, 3'b001, 1, 1'b1, 32'hCAFE_F00D, 1'b0);
`ifdef APB_TIMEOUT_EN
        apply_stimulus(1'b0, 32'h0000_3000, 32'h0, 4'h0, 3'b000, 1000, 1'b0, 32'h7777_8888, 1'b0);
        apply_stimulus(1'b0, 32'h0000_3004, 32'h0, 4'h0, 3'b000, TO - 1, 1'b0, 32'h9999_0000, 1'b0);
`endif

        // Hold the response 5 cycles with the next command already waiting.
        hold_left = 5;
        apply_stimulus(1'b0, 32'h0000_1010, 32'h0, 4'h0, 3'b100, 0, 1'b0, 32'hA5A5_5A5A, 1'b0);
        wait_rsp_valid();
        apply_stimulus(1'b1, 32'h0000_2020, 32'hFEED_FACE, 4'b1100, 3'b011, 1, 1'b0, 32'h0, 1'b1);

        // Reset in the middle of ACCESS drops the bus and the pending response.
        apply_stimulus(1'b0, 32'h0000_3008, 32'h0, 4'h0, 3'b000, 10, 1'b0, 32'h0BAD_0BAD, 1'b0);
        n = 0;
        while (!bus.penable && n < 50) begin
            @(negedge pclk);
            n++;
        end
        preset = 1'b1;
        @(negedge pclk);
        check_output("midreset_psel", 64'(bus.psel), 64'd0);
        check_output("midreset_penable", 64'(bus.penable), 64'd0);
        check_output("midreset_rsp_valid", 64'(rsp_valid), 64'd0);
        check_output("midreset_cmd_ready", 64'(cmd_ready), 64'd1);
        exp_q.delete();
        cfg_wait = 0;
        @(negedge pclk);
        preset = 1'b0;

        random_bp = 1'b1;
        for (int t = 0; t < 40; t++) begin
            slave = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, NS - 1)) : int'($urandom_range(NS, 7));
            addr = (32'(slave) << 12) | (32'($urandom_range(0, 1023)) << 2);
            if ($urandom_range(0, 7) == 0) addr = addr | 32'($urandom_range(1, 3));
            if ($urandom_range(0, 15) == 0) addr = $urandom;
            wait_n = $urandom_range(0, 3);
            if ($urandom_range(0, 9) == 0) wait_n = 8;
`ifdef APB_TIMEOUT_EN
            if ($urandom_range(0, 9) == 0) wait_n = $urandom_range(TO - 2, 40);
`endif
            apply_stimulus(1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)),
                           3'($urandom_range(0, 7)), wait_n, 1'($urandom_range(0, 3) == 0), $urandom, 1'b0);
        end

        n = 0;
        while ((exp_q.size() != 0 || pending != 0 || rsp_valid) && n < 1000) begin
            @(posedge pclk); #1;
            n++;
        end
        check_output("drain_outstanding", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
